// File: rtl/hazard_unit_mc_pkg.sv
// Shared encodings for the multi-cycle-aware hazard controller:
// E-operand forwarding selects and the multi-cycle execute FSM states.
package hazard_unit_mc_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } mc_state_t;

endpackage

// File: rtl/hazard_unit_mc_fwd_sel.sv
// Forwarding select for one E-stage operand; the M-stage result wins over W
// because it is the younger write to the same register.
module fwd_sel
    import hazard_unit_mc_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              en,
    input  logic [REG_AW-1:0] rse,
    input  logic [REG_AW-1:0] rdm,
    input  logic              regwritem,
    input  logic [REG_AW-1:0] rdw,
    input  logic              regwritew,
    output logic [1:0]        fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (en && rse != '0) begin
            if (regwritem && rse == rdm) begin
                fwd = FWD_MEM;
            end else if (regwritew && rse == rdw) begin
                fwd = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding, load-use / RAW
// stalls, branch flush, multi-cycle execute stall FSM, data-memory wait stall.
module hazard_unit_mc
    import hazard_unit_mc_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1d,
    input  logic [REG_AW-1:0] rs2d,
    input  logic [REG_AW-1:0] rs1e,
    input  logic [REG_AW-1:0] rs2e,
    input  logic [REG_AW-1:0] rde,
    input  logic              regwritee,
    input  logic              resultsrce0,
    input  logic              pcsrce,
    input  logic              mc_start_e,
    input  logic              mc_done,
    input  logic              regwritem,
    input  logic [REG_AW-1:0] rdm,
    input  logic              dmem_req_m,
    input  logic              dmem_ready_m,
    input  logic              regwritew,
    input  logic [REG_AW-1:0] rdw,
    input  logic              perf_clr,
    output logic              stallf,
    output logic              stalld,
    output logic              stalle,
    output logic              stallm,
    output logic              flushd,
    output logic              flushe,
    output logic              flushm,
    output logic              flushw,
    output logic [1:0]        forwardae,
    output logic [1:0]        forwardbe,
    output logic              mc_busy,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush
);

    localparam bit FWD_ON = (FWD_EN != 0);

    mc_state_t state, state_n;
    logic memstall, mcstall, lwstall, rawstall, dstall, branch;
    logic dep1, dep2;

    assign memstall = dmem_req_m & ~dmem_ready_m;
    assign mcstall  = ((state == ST_RUN & mc_start_e) | (state == ST_MC_WAIT)) & ~mc_done & ~memstall;
    assign lwstall  = resultsrce0 & (rde != '0) & ((rs1d == rde) | (rs2d == rde));

    // Without forwarding every in-flight writer of a D source must drain first.
    assign dep1 = (rs1d != '0) & ((regwritee & (rs1d == rde)) | (regwritem & (rs1d == rdm)) |
                                  (regwritew & (rs1d == rdw)));
    assign dep2 = (rs2d != '0) & ((regwritee & (rs2d == rde)) | (regwritem & (rs2d == rdm)) |
                                  (regwritew & (rs2d == rdw)));
    assign rawstall = lwstall | dep1 | dep2;

    assign dstall = (FWD_ON ? lwstall : rawstall) & ~memstall & ~mcstall;
    assign branch = pcsrce & ~memstall & ~mcstall;
    assign mc_busy = (state == ST_MC_WAIT);

    always_comb begin
        state_n = state;
        if (!memstall) begin
            case (state)
                ST_RUN:     if (mc_start_e && !mc_done) state_n = ST_MC_WAIT;
                ST_MC_WAIT: if (mc_done) state_n = ST_RUN;
                default:    state_n = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_n;
    end

    always_comb begin
        stallf = 1'b0;
        stalld = 1'b0;
        stalle = 1'b0;
        stallm = 1'b0;
        flushd = 1'b0;
        flushe = 1'b0;
        flushm = 1'b0;
        flushw = 1'b0;
        if (!rst_n) begin
            flushd = 1'b1;
            flushe = 1'b1;
            flushm = 1'b1;
            flushw = 1'b1;
        end else if (memstall) begin
            stallf = 1'b1;
            stalld = 1'b1;
            stalle = 1'b1;
            stallm = 1'b1;
            flushw = 1'b1;
        end else begin
            if (mcstall) begin
                stallf = 1'b1;
                stalld = 1'b1;
                stalle = 1'b1;
                flushm = 1'b1;
            end else if (dstall) begin
                stallf = 1'b1;
                stalld = 1'b1;
                flushe = 1'b1;
            end
            if (branch) begin
                flushd = 1'b1;
                flushe = 1'b1;
            end
        end
    end

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .en(FWD_ON & rst_n), .rse(rs1e), .rdm(rdm), .regwritem(regwritem),
        .rdw(rdw), .regwritew(regwritew), .fwd(forwardae)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .en(FWD_ON & rst_n), .rse(rs2e), .rdm(rdm), .regwritem(regwritem),
        .rdw(rdw), .regwritew(regwritew), .fwd(forwardbe)
    );

    // Saturating counters; a clear in the same cycle as an event wins.
    always_ff @(posedge clk) begin
        if (!rst_n || perf_clr) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (stallf && perf_stall != '1) perf_stall <= perf_stall + PERF_W'(1);
            if (branch && perf_flush != '1) perf_flush <= perf_flush + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: a forwarding build and a no-forwarding build with
// a 4-bit counter width share one stimulus stream and one behavioural model.
module tb_hazard_unit_mc;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwritee, resultsrce0, pcsrce, mc_start_e, mc_done;
    logic       regwritem, dmem_req_m, dmem_ready_m, regwritew, perf_clr;

    logic        sf1, sd1, se1, sm1, fd1, fe1, fm1, fw1, busy1;
    logic [1:0]  fa1, fb1;
    logic [31:0] ps1, pf1;
    logic        sf0, sd0, se0, sm0, fd0, fe0, fm0, fw0, busy0;
    logic [1:0]  fa0, fb0;
    logic [3:0]  ps0, pf0;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_unit_mc #(.REG_AW(5), .FWD_EN(1), .PERF_W(32)) u_fwd (
        .clk(clk), .rst_n(rst_n), .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e),
        .rde(rde), .regwritee(regwritee), .resultsrce0(resultsrce0), .pcsrce(pcsrce),
        .mc_start_e(mc_start_e), .mc_done(mc_done), .regwritem(regwritem), .rdm(rdm),
        .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m), .regwritew(regwritew),
        .rdw(rdw), .perf_clr(perf_clr), .stallf(sf1), .stalld(sd1), .stalle(se1),
        .stallm(sm1), .flushd(fd1), .flushe(fe1), .flushm(fm1), .flushw(fw1),
        .forwardae(fa1), .forwardbe(fb1), .mc_busy(busy1), .perf_stall(ps1), .perf_flush(pf1)
    );

    hazard_unit_mc #(.REG_AW(5), .FWD_EN(0), .PERF_W(4)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e),
        .rde(rde), .regwritee(regwritee), .resultsrce0(resultsrce0), .pcsrce(pcsrce),
        .mc_start_e(mc_start_e), .mc_done(mc_done), .regwritem(regwritem), .rdm(rdm),
        .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m), .regwritew(regwritew),
        .rdw(rdw), .perf_clr(perf_clr), .stallf(sf0), .stalld(sd0), .stalle(se0),
        .stallm(sm0), .flushd(fd0), .flushe(fe0), .flushm(fm0), .flushw(fw0),
        .forwardae(fa0), .forwardbe(fb0), .mc_busy(busy0), .perf_stall(ps0), .perf_flush(pf0)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Output vector layout: {stallf,stalld,stalle,stallm,flushd,flushe,flushm,flushw,fa,fb,busy}
    bit      model_ok = 0;
    bit      busy_m   = 0;
    longint  cnt_s[2];
    longint  cnt_f[2];
    longint  cnt_max[2];
    logic [12:0] exp_q1[$];
    logic [12:0] exp_q0[$];

    function automatic logic [1:0] fwd_of(input bit fe, input logic [4:0] rs);
        if (!fe || rs == 0)               return 2'b00;
        if (regwritem && rs == rdm)       return 2'b10;
        if (regwritew && rs == rdw)       return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit depends(input logic [4:0] rs);
        if (rs == 0) return 0;
        return (regwritee && rs == rde) || (regwritem && rs == rdm) || (regwritew && rs == rdw);
    endfunction

    function automatic logic [12:0] model_out(input bit fe, input bit busy);
        bit mem_wait, mc_wait, load_use, d_haz;
        logic [3:0] st, fl;
        logic [1:0] a, b;
        if (!rst_n) return {4'b0000, 4'b1111, 4'b0000, busy};
        a = fwd_of(fe, rs1e);
        b = fwd_of(fe, rs2e);
        mem_wait = dmem_req_m && !dmem_ready_m;
        if (mem_wait) return {4'b1111, 4'b0001, a, b, busy};
        mc_wait  = (busy || mc_start_e) && !mc_done;
        if (mc_wait) return {4'b1110, 4'b0010, a, b, busy};
        load_use = resultsrce0 && rde != 0 && (rs1d == rde || rs2d == rde);
        d_haz    = fe ? load_use : (load_use || depends(rs1d) || depends(rs2d));
        st = 4'b0000;
        fl = 4'b0000;
        if (d_haz)  begin st = 4'b1100; fl[2] = 1'b1; end
        if (pcsrce) fl[3:2] = 2'b11;
        return {st, fl, a, b, busy};
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [12:0] e1, e0;
        bit mem_wait;
        if (model_ok) begin
            exp_q1.push_back(model_out(1'b1, busy_m));
            exp_q0.push_back(model_out(1'b0, busy_m));
            e1 = exp_q1.pop_front();
            e0 = exp_q0.pop_front();
            check("outs_fwd",   {19'd0, sf1, sd1, se1, sm1, fd1, fe1, fm1, fw1, fa1, fb1, busy1}, {19'd0, e1});
            check("outs_nofwd", {19'd0, sf0, sd0, se0, sm0, fd0, fe0, fm0, fw0, fa0, fb0, busy0}, {19'd0, e0});
            check("perf_stall_fwd",   ps1,          32'(cnt_s[1]));
            check("perf_flush_fwd",   pf1,          32'(cnt_f[1]));
            check("perf_stall_nofwd", {28'd0, ps0}, 32'(cnt_s[0]));
            check("perf_flush_nofwd", {28'd0, pf0}, 32'(cnt_f[0]));
            // advance counters using this cycle's expected stallf / accepted branch
            for (int d = 0; d < 2; d++) begin
                logic [12:0] ev;
                bit br_taken;
                ev = (d == 1) ? e1 : e0;
                mem_wait = dmem_req_m && !dmem_ready_m;
                br_taken = rst_n && pcsrce && !mem_wait && !((busy_m || mc_start_e) && !mc_done);
                if (!rst_n || perf_clr) begin
                    cnt_s[d] = 0;
                    cnt_f[d] = 0;
                end else begin
                    if (ev[12] && cnt_s[d] < cnt_max[d]) cnt_s[d]++;
                    if (br_taken && cnt_f[d] < cnt_max[d]) cnt_f[d]++;
                end
            end
        end
        mem_wait = dmem_req_m && !dmem_ready_m;
        if (!rst_n) begin
            busy_m   = 0;
            cnt_s    = '{0, 0};
            cnt_f    = '{0, 0};
            model_ok = 1;
        end else if (!mem_wait) begin
            busy_m = busy_m ? !mc_done : (mc_start_e && !mc_done);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        regwritee = 0; resultsrce0 = 0; pcsrce = 0; mc_start_e = 0; mc_done = 0;
        regwritem = 0; dmem_req_m = 0; dmem_ready_m = 0; regwritew = 0; perf_clr = 0;
    endtask

    task automatic drive_random();
        rst_n        = ($urandom_range(0, 99) != 0);
        rs1d         = 5'($urandom_range(0, 3));
        rs2d         = 5'($urandom_range(0, 3));
        rs1e         = 5'($urandom_range(0, 3));
        rs2e         = 5'($urandom_range(0, 3));
        rde          = 5'($urandom_range(0, 3));
        rdm          = 5'($urandom_range(0, 3));
        rdw          = 5'($urandom_range(0, 3));
        regwritee    = 1'($urandom_range(0, 1));
        resultsrce0  = ($urandom_range(0, 3) == 0);
        pcsrce       = ($urandom_range(0, 4) == 0);
        mc_start_e   = ($urandom_range(0, 5) == 0);
        mc_done      = ($urandom_range(0, 2) == 0);
        regwritem    = 1'($urandom_range(0, 1));
        dmem_req_m   = ($urandom_range(0, 2) == 0);
        dmem_ready_m = 1'($urandom_range(0, 1));
        regwritew    = 1'($urandom_range(0, 1));
        perf_clr     = ($urandom_range(0, 49) == 0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        cnt_max[1] = 64'hFFFF_FFFF;
        cnt_max[0] = 15;
        rst_n = 0;
        idle();
        repeat (3) cyc();
        #3;
        check("rst_flushd", {31'd0, fd1}, 32'd1);
        check("rst_flushw", {31'd0, fw1}, 32'd1);
        check("rst_stallf", {31'd0, sf1}, 32'd0);
        cyc(); rst_n = 1; idle();

        // forwarding: M beats W, x0 never forwards, no-forward build forces RF
        cyc(); idle();
        rdm = 5; regwritem = 1; rdw = 5; regwritew = 1; rs1e = 5; rs2e = 5;
        #3;
        check("fwd_a_mem", {30'd0, fa1}, 32'd2);
        check("fwd_b_mem", {30'd0, fb1}, 32'd2);
        check("nofwd_a",   {30'd0, fa0}, 32'd0);
        cyc(); rdm = 6;
        #3;
        check("fwd_a_wb", {30'd0, fa1}, 32'd1);
        cyc(); rdm = 0; rdw = 0; rs1e = 0; rs2e = 0;
        #3;
        check("fwd_x0", {30'd0, fa1}, 32'd0);

        // load-use
        cyc(); idle(); resultsrce0 = 1; rde = 3; regwritee = 1; rs1d = 3;
        #3;
        check("lw_stallf", {31'd0, sf1}, 32'd1);
        check("lw_flushe", {31'd0, fe1}, 32'd1);
        cyc(); rde = 0; rs1d = 0;
        #3;
        check("lw_x0", {31'd0, sf1}, 32'd0);

        // multi-cycle op completing four cycles after issue
        cyc(); idle(); perf_clr = 1;
        cyc(); idle();
        for (int i = 0; i < 4; i++) begin
            cyc(); mc_start_e = 1; mc_done = 0;
            #3;
            check("mc_stallf", {31'd0, sf1}, 32'd1);
            check("mc_flushm", {31'd0, fm1}, 32'd1);
        end
        cyc(); mc_done = 1;
        #3;
        check("mc_done_nostall", {31'd0, sf1}, 32'd0);
        cyc(); idle();
        #3;
        check("mc_perf_stall", ps1, 32'd4);
        check("mc_busy_clear", {31'd0, busy1}, 32'd0);

        // memory wait during MC_WAIT, done pulsed while memory holds everything
        cyc(); mc_start_e = 1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc(); dmem_req_m = 1; dmem_ready_m = 0; mc_done = (i == 1);
            #3;
            check("mem_stallm", {31'd0, sm1}, 32'd1);
            check("mem_flushm", {31'd0, fm1}, 32'd0);
            check("mem_busy",   {31'd0, busy1}, 32'd1);
        end
        cyc(); dmem_req_m = 0; mc_done = 0;
        #3;
        check("mem_mc_held", {31'd0, sf1}, 32'd1);
        cyc(); mc_done = 1;
        cyc(); idle();

        // branch held off by memory wait
        for (int i = 0; i < 2; i++) begin
            cyc(); pcsrce = 1; dmem_req_m = 1; dmem_ready_m = 0;
            #3;
            check("br_held", {31'd0, fd1}, 32'd0);
        end
        cyc(); dmem_ready_m = 1;
        #3;
        check("br_flushd", {31'd0, fd1}, 32'd1);
        check("br_flushe", {31'd0, fe1}, 32'd1);
        cyc(); idle();
        #3;
        check("br_perf", pf1, 32'd1);

        // reset mid MC_WAIT
        cyc(); mc_start_e = 1;
        cyc();
        #3;
        check("rst_mc_busy", {31'd0, busy1}, 32'd1);
        cyc(); rst_n = 0;
        #3;
        check("rst_mid_flushm", {31'd0, fm1}, 32'd1);
        cyc(); rst_n = 1; idle();
        #3;
        check("rst_busy_gone", {31'd0, busy1}, 32'd0);
        check("rst_perf_zero", ps1, 32'd0);

        // RAW on M without forwarding
        cyc(); regwritem = 1; rdm = 2; rs1d = 2; rs1e = 2;
        #3;
        check("raw_nofwd_stall", {31'd0, sf0}, 32'd1);
        check("raw_fwd_nostall", {31'd0, sf1}, 32'd0);
        check("raw_nofwd_fa",    {30'd0, fa0}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            cyc();
            drive_random();
        end
        cyc(); idle(); rst_n = 1;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
